// File: rtl/velocimetro_pkg.sv
// velocimetro_pkg: shared widths, speed factor, divider FSM states and result saturation.
package velocimetro_pkg;
  localparam int FACTOR_VEL = 36;
  localparam int ANCHO_VEL = 16;
  localparam int ANCHO_DIVIDENDO = 24;
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} estado_t;
  function automatic logic [ANCHO_VEL-1:0] saturar(input logic [ANCHO_DIVIDENDO-1:0] q);
    return (|q[ANCHO_DIVIDENDO-1:ANCHO_VEL]) ? '1 : q[ANCHO_VEL-1:0];
  endfunction
endpackage

// File: rtl/calcular_velocidad_if.sv
// calcular_velocidad_if: circumference/sensor inputs and speed outputs of the speed calculator.
interface calcular_velocidad_if;
  import velocimetro_pkg::*;
  logic [ANCHO_VEL-1:0] circunferencia;
  logic sensor;
  logic [ANCHO_VEL-1:0] velocidad;
  logic valido;
  logic detenido;
  logic ocupado;
  modport master(output circunferencia, sensor, input velocidad, valido, detenido, ocupado);
  modport slave(input circunferencia, sensor, output velocidad, valido, detenido, ocupado);
endinterface

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: 24/16 restoring divider, one quotient bit per cycle, start/busy/fin handshake.
module divisor_secuencial
  import velocimetro_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ANCHO_DIVIDENDO-1:0] dividendo,
  input  logic [ANCHO_VEL-1:0]       divisor,
  output logic                       ocupado,
  output logic                       fin,
  output logic [ANCHO_DIVIDENDO-1:0] cociente
);
  estado_t estado;
  logic [4:0] iter;
  logic [ANCHO_DIVIDENDO-1:0] q;
  logic [ANCHO_VEL-1:0] r, d;
  logic [ANCHO_VEL:0] r_sh, dif;
  logic bit_q;
  // q shifts dividend bits out at the top and quotient bits in at the bottom
  assign r_sh = {r, q[ANCHO_DIVIDENDO-1]};
  assign dif = r_sh - {1'b0, d};
  assign bit_q = ~dif[ANCHO_VEL];
  assign cociente = {q[ANCHO_DIVIDENDO-2:0], bit_q};
  assign fin = (estado == DIVIDE) && (iter == 5'(ANCHO_DIVIDENDO - 1));
  assign ocupado = (estado == DIVIDE);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      iter <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
    end else if (estado != DIVIDE) begin
      estado <= start ? DIVIDE : IDLE;
      if (start) begin
        q <= dividendo;
        r <= '0;
        d <= divisor;
        iter <= '0;
      end
    end else begin
      q <= cociente;
      r <= bit_q ? dif[ANCHO_VEL-1:0] : r_sh[ANCHO_VEL-1:0];
      iter <= iter + 5'd1;
      estado <= fin ? DONE : DIVIDE;
    end
  end
endmodule

// File: rtl/calcular_velocidad.sv
// calcular_velocidad: measures wheel revolution period in ms and converts it to speed in 0.1 km/h.
module calcular_velocidad
  import velocimetro_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int MIN_PERIOD_MS = 2,
  parameter int TIMEOUT_MS    = 3000
) (
  input logic clk,
  input logic reset,
  calcular_velocidad_if.slave bus
);
  localparam int CICLOS_MS = CLK_FREQ_HZ / 1000;
  localparam int PW = $clog2(CICLOS_MS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CICLOS_MS - 1);
  localparam logic [ANCHO_VEL-1:0] MIN_P = ANCHO_VEL'(MIN_PERIOD_MS);
  localparam logic [ANCHO_VEL-1:0] TOUT = ANCHO_VEL'(TIMEOUT_MS);
  if (MIN_PERIOD_MS < 1 || CICLOS_MS < 2) begin : g_param_check
    $error("calcular_velocidad: MIN_PERIOD_MS must be >= 1 and CLK_FREQ_HZ >= 2000");
  end
  logic s1, s2, prev, primed;
  logic [PW-1:0] presc;
  logic [ANCHO_VEL-1:0] periodo, velocidad;
  logic valido, detenido;
  logic flanco, ms_tick, acept, timeout, start, fin;
  logic [ANCHO_DIVIDENDO-1:0] cociente;
  assign flanco = s2 & ~prev;
  assign ms_tick = (presc == PRESC_MAX);
  assign acept = flanco && (periodo >= MIN_P || !primed);
  assign timeout = primed && (periodo == TOUT);
  // an edge coinciding with a timeout only re-primes
  assign start = acept && primed && !timeout;
  divisor_secuencial u_div (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividendo(ANCHO_DIVIDENDO'(FACTOR_VEL * bus.circunferencia)),
    .divisor(periodo),
    .ocupado(bus.ocupado),
    .fin(fin),
    .cociente(cociente)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {prev, s2, s1} <= '0;
      presc <= '0;
      periodo <= '0;
      primed <= 1'b0;
      velocidad <= '0;
      valido <= 1'b0;
      detenido <= 1'b1;
    end else begin
      {prev, s2, s1} <= {s2, s1, bus.sensor};
      presc <= (acept || ms_tick) ? '0 : presc + 1'b1;
      periodo <= acept ? '0 : (ms_tick && periodo < TOUT) ? periodo + 16'd1 : periodo;
      primed <= acept || (primed && !timeout);
      valido <= timeout || fin;
      velocidad <= timeout ? '0 : fin ? saturar(cociente) : velocidad;
      detenido <= timeout || (detenido && !fin);
    end
  end
  assign bus.velocidad = velocidad;
  assign bus.valido = valido;
  assign bus.detenido = detenido;
endmodule
